// File: rtl/ram_skew_feeder.sv
// Row-ROM consumer: fetches num_rows rows, splits each into byte lanes and skews lane k by k cycles.
// Optional FEEDER_CYCLE_CNT_EN adds a saturating busy-cycle counter output (cycle_cnt).
module ram_skew_feeder #(
    parameter int unsigned LANES      = 3,
    parameter int unsigned LANE_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [ADDR_WIDTH-1:0]         base_addr,
    input  logic [ADDR_WIDTH:0]           num_rows,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    input  logic [LANES*LANE_WIDTH-1:0]   ram_data,
    output logic [LANES*LANE_WIDTH-1:0]   lane_data,
    output logic [LANES-1:0]              lane_valid,
    output logic                          busy,
    output logic                          done
`ifdef FEEDER_CYCLE_CNT_EN
    ,
    output logic [15:0]                   cycle_cnt
`endif
);

    localparam int unsigned CntW   = ADDR_WIDTH + 1;
    localparam int unsigned DrainW = $clog2(LANES + 2);
    localparam logic [CntW-1:0]   MaxRows   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [CntW-1:0]   OneRow    = CntW'(1);
    localparam logic [DrainW-1:0] DrainLast = DrainW'(LANES);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

    state_e                state_q;
    logic [CntW-1:0]       rows_left_q;
    logic [DrainW-1:0]     drain_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  rd_valid_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rows_left_q <= '0;
            drain_q     <= '0;
            addr_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            // ROM data for an address issued this cycle arrives next cycle
            rd_valid_q <= (state_q == StFetch);
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (num_rows == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= StFetch;
                            busy_q      <= 1'b1;
                            addr_q      <= base_addr;
                            rows_left_q <= (num_rows > MaxRows) ? MaxRows : num_rows;
                        end
                    end
                end
                StFetch: begin
                    if (rows_left_q == OneRow) begin
                        state_q <= StDrain;
                        drain_q <= '0;
                    end else begin
                        rows_left_q <= rows_left_q - 1'b1;
                        addr_q      <= addr_q + 1'b1;
                    end
                end
                StDrain: begin
                    if (drain_q == DrainLast) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ram_addr = addr_q;
    assign busy     = busy_q;
    assign done     = done_q;

    // Lane k: one capture stage plus k skew stages, packed as a shift register.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam int unsigned Depth = k + 1;
        logic [Depth-1:0]            v_q;
        logic [Depth*LANE_WIDTH-1:0] d_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_q <= '0;
                d_q <= '0;
            end else begin
                v_q <= (v_q << 1) | Depth'(rd_valid_q);
                d_q <= (d_q << LANE_WIDTH)
                     | (Depth*LANE_WIDTH)'(ram_data[k*LANE_WIDTH +: LANE_WIDTH]);
            end
        end

        assign lane_valid[k] = v_q[k];
        assign lane_data[k*LANE_WIDTH +: LANE_WIDTH] =
            v_q[k] ? d_q[k*LANE_WIDTH +: LANE_WIDTH] : '0;
    end

`ifdef FEEDER_CYCLE_CNT_EN
    logic [15:0] cycle_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt_q <= '0;
        end else if (state_q == StIdle && start) begin
            cycle_cnt_q <= '0;
        end else if (busy_q && cycle_cnt_q != 16'hFFFF) begin
            cycle_cnt_q <= cycle_cnt_q + 16'd1;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_ram_skew_feeder.sv
// Bench for ram_skew_feeder: directed and random jobs against a per-cycle timing model.
module tb_ram_skew_feeder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  base_addr;
    logic [4:0]  num_rows;
    logic [3:0]  ram_addr;
    logic [23:0] ram_data;
    logic [23:0] lane_data;
    logic [2:0]  lane_valid;
    logic        busy;
    logic        done;
`ifdef FEEDER_CYCLE_CNT_EN
    logic [15:0] cycle_cnt;
`endif

    ram_skew_feeder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .num_rows   (num_rows),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .lane_data  (lane_data),
        .lane_valid (lane_valid),
        .busy       (busy),
        .done       (done)
`ifdef FEEDER_CYCLE_CNT_EN
        ,
        .cycle_cnt  (cycle_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous-read ROM model
    logic [23:0] rom [16];
    always @(posedge clk) ram_data <= rom[ram_addr];

    int         vectors     = 0;
    int         miscompares = 0;
    logic [3:0] exp_addr;
    int         exp_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".done"}, 32'(done), 0);
        chk({tag, ".lane_valid"}, 32'(lane_valid), 0);
        chk({tag, ".lane_data"}, 32'(lane_data), 0);
        chk({tag, ".ram_addr"}, 32'(ram_addr), 32'(exp_addr));
`ifdef FEEDER_CYCLE_CNT_EN
        chk({tag, ".cycle_cnt"}, 32'(cycle_cnt), 32'(exp_cnt));
`endif
    endtask

    // Called just before the acceptance edge with start asserted; returns during the done cycle.
    task automatic check_job(input logic [3:0] base, input int nreq, input bit keep_start);
        int          n, dc, nb, i;
        logic [23:0] ed;
        logic [2:0]  ev;
        logic [3:0]  a;
        n  = (nreq > 16) ? 16 : nreq;
        dc = (n == 0) ? 1 : n + 5;
        nb = (n == 0) ? 0 : n + 4;
        @(posedge clk); #1;
        if (!keep_start) start = 1'b0;
        base_addr = 4'($urandom);
        num_rows  = 5'($urandom);
        for (int c = 1; c <= dc; c++) begin
            ed = '0;
            ev = '0;
            for (int k = 0; k < 3; k++) begin
                i = c - 3 - k;
                if (i >= 0 && i < n) begin
                    a = base + 4'(i);
                    ev[k] = 1'b1;
                    ed[8*k +: 8] = rom[a][8*k +: 8];
                end
            end
            if (n > 0) exp_addr = (c <= n) ? base + 4'(c - 1) : base + 4'(n - 1);
            chk("job.ram_addr", 32'(ram_addr), 32'(exp_addr));
            chk("job.lane_valid", 32'(lane_valid), 32'(ev));
            chk("job.lane_data", 32'(lane_data), 32'(ed));
            chk("job.busy", 32'(busy), 32'(n > 0 && c <= nb));
            chk("job.done", 32'(done), 32'(c == dc));
`ifdef FEEDER_CYCLE_CNT_EN
            chk("job.cycle_cnt", 32'(cycle_cnt), 32'((c - 1 < nb) ? c - 1 : nb));
`endif
            if (c < dc) begin
                @(posedge clk); #1;
            end
        end
        exp_cnt = nb;
    endtask

    task automatic launch(input logic [3:0] base, input int n, input bit keep_start);
        @(posedge clk); #1;
        check_idle("idle");
        start     = 1'b1;
        base_addr = base;
        num_rows  = 5'(n);
        check_job(base, n, keep_start);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        num_rows  = '0;
        exp_addr  = '0;
        exp_cnt   = 0;
        for (int r = 0; r < 16; r++) rom[r] = 24'($urandom);
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        rst_n = 1'b1;

        rom[0] = 24'h030201;
        rom[1] = 24'h060504;
        rom[2] = 24'h090807;
        launch(4'h0, 3, 1'b0);
        launch(4'hE, 4, 1'b0);   // address wraps E,F,0,1
        launch(4'h9, 0, 1'b0);   // empty job
        launch(4'h3, 16, 1'b0);
        launch(4'h7, 20, 1'b0);  // clamped to 16

        // start held high: ignored while busy and in the done cycle
        launch(4'h5, 3, 1'b1);
        base_addr = 4'hB;
        num_rows  = 5'd2;
        @(posedge clk); #1;
        check_idle("held_idle");
        check_job(4'hB, 2, 1'b0);

        // Reset mid-job aborts without a done pulse
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = 4'h5;
        num_rows  = 5'd10;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n    = 1'b1;
        exp_addr = '0;
        exp_cnt  = 0;
        check_idle("rst_abort");
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            chk("rst_abort.done", 32'(done), 0);
            chk("rst_abort.busy", 32'(busy), 0);
            chk("rst_abort.lane_valid", 32'(lane_valid), 0);
        end

        for (int r = 0; r < 8; r++) begin
            for (int j = 0; j < 16; j++) rom[j] = 24'($urandom);
            launch(4'($urandom), int'($urandom_range(0, 20)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
